ship_action_engine: RTL and testbench

//  Game-side counterpart of a team logic block: consumes one team's attempted accelerations/actions
//  and produces that team's ship state (position, energy, destroyed, shield/cloak, bullets).

---
 rtl/ship_action_engine_if.sv | 45 ++++
 rtl/ship_action_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_ship_action_engine.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ship_action_engine_if.sv
// ship_action_engine_if
//   Bundles the per-team game-cycle traffic between the team logic/arena and
//   the ship action engine.
//   Arena -> engine (master drives): step, x_a, y_a, attempt_fire,
//     attempt_shield, attempt_cloak, fire_dir, hit.
//   Engine -> arena (slave drives): x, y, energy, destroyed, shield_up,
//     cloaked, bullet_active, bullet_x, bullet_y, bullet_dir.
//   Every per-ship signal is an unpacked array indexed [NUM_SHIPS-1:0].
interface ship_action_engine_if #(
  parameter int NUM_SHIPS = 3
);
  logic              step;
  logic signed [3:0] x_a            [NUM_SHIPS-1:0];
  logic signed [3:0] y_a            [NUM_SHIPS-1:0];
  logic              attempt_fire   [NUM_SHIPS-1:0];
  logic              attempt_shield [NUM_SHIPS-1:0];
  logic              attempt_cloak  [NUM_SHIPS-1:0];
  logic [1:0]        fire_dir       [NUM_SHIPS-1:0];
  logic              hit            [NUM_SHIPS-1:0];

  logic signed [7:0] x              [NUM_SHIPS-1:0];
  logic signed [7:0] y              [NUM_SHIPS-1:0];
  logic [7:0]        energy         [NUM_SHIPS-1:0];
  logic              destroyed      [NUM_SHIPS-1:0];
  logic              shield_up      [NUM_SHIPS-1:0];
  logic              cloaked        [NUM_SHIPS-1:0];
  logic              bullet_active  [NUM_SHIPS-1:0];
  logic signed [7:0] bullet_x       [NUM_SHIPS-1:0];
  logic signed [7:0] bullet_y       [NUM_SHIPS-1:0];
  logic [1:0]        bullet_dir     [NUM_SHIPS-1:0];

  modport master (
    output step, x_a, y_a, attempt_fire, attempt_shield, attempt_cloak,
           fire_dir, hit,
    input  x, y, energy, destroyed, shield_up, cloaked, bullet_active,
           bullet_x, bullet_y, bullet_dir
  );

  modport slave (
    input  step, x_a, y_a, attempt_fire, attempt_shield, attempt_cloak,
           fire_dir, hit,
    output x, y, energy, destroyed, shield_up, cloaked, bullet_active,
           bullet_x, bullet_y, bullet_dir
  );
endinterface

// File: rtl/ship_action_engine.sv
// ship_action_engine
//   Game-side model of one team's ships. On every single-clock `step` pulse
//   each live ship arbitrates its fire/cloak/shield requests against its
//   energy, integrates acceleration into velocity and position, advances its
//   bullet and applies enemy hits. All outputs come straight from registers
//   and are valid the cycle after the step.
// Ports
//   clk    : clock
//   reset  : synchronous, active-high; wins over step
//   bus    : ship_action_engine_if.slave (requests in, ship/bullet state out)
module ship_action_engine #(
  parameter int NUM_SHIPS    = 3,
  parameter int MAX_ACCEL    = 4,
  parameter int MAX_SPEED    = 16,
  parameter int BOARD_LIMIT  = 64,
  parameter int MAX_ENERGY   = 80,
  parameter int RECOUP       = 15,
  parameter int FIRE_COST    = 30,
  parameter int CLOAK_COST   = 15,
  parameter int SHIELD_COST  = 25,
  parameter int BULLET_SPEED = 9,
  parameter int BULLET_TIME  = 6,
  parameter int INIT_X       = -40
) (
  input logic                clk,
  input logic                reset,
  ship_action_engine_if.slave bus
);

  localparam logic signed [8:0] ACC_LIM  = 9'(MAX_ACCEL);
  localparam logic signed [8:0] SPD_LIM  = 9'(MAX_SPEED);
  localparam logic signed [8:0] POS_LIM  = 9'(BOARD_LIMIT);
  localparam logic signed [7:0] POS_SAT  = 8'sd127;
  localparam logic signed [7:0] X_RESET  = 8'(INIT_X);
  localparam logic signed [7:0] B_STEP   = 8'(BULLET_SPEED);
  localparam logic [8:0]        E_MAX    = 9'(MAX_ENERGY);
  localparam logic [7:0]        E_MAX8   = 8'(MAX_ENERGY);
  localparam logic [8:0]        E_RECOUP = 9'(RECOUP);
  localparam logic [8:0]        E_FIRE   = 9'(FIRE_COST);
  localparam logic [8:0]        E_CLOAK  = 9'(CLOAK_COST);
  localparam logic [8:0]        E_SHIELD = 9'(SHIELD_COST);
  localparam logic [2:0]        LIFE_INIT = 3'(BULLET_TIME);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  // Symmetric clamp to [-lim, +lim].
  function automatic logic signed [8:0] clamp9(input logic signed [8:0] v,
                                               input logic signed [8:0] lim);
    logic signed [8:0] r;
    if (v > lim) begin
      r = lim;
    end else if (v < -lim) begin
      r = -lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // True once a coordinate has left the playing field.
  function automatic logic off_board(input logic signed [8:0] p);
    return (p > POS_LIM) || (p < -POS_LIM);
  endfunction

  // Off-board coordinates are pinned to +/-127 so the stored value stays
  // unambiguous in 8 bits; on-board values fit without loss.
  function automatic logic signed [7:0] store_pos(input logic signed [8:0] p);
    logic signed [7:0] r;
    if (p > POS_LIM) begin
      r = POS_SAT;
    end else if (p < -POS_LIM) begin
      r = -POS_SAT;
    end else begin
      r = p[7:0];
    end
    return r;
  endfunction

  for (genvar i = 0; i < NUM_SHIPS; i++) begin : g_ship
    localparam logic signed [7:0] Y_RESET = 8'((i - 1) * 16);

    logic signed [7:0] x_r, y_r, bullet_x_r, bullet_y_r;
    logic signed [8:0] vx_r, vy_r;
    logic [7:0]        energy_r;
    logic [1:0]        bullet_dir_r;
    logic [2:0]        life_r;
    logic              destroyed_r, shield_up_r, cloaked_r, bullet_active_r;

    logic              fire_grant_s, cloak_grant_s, shield_grant_s, kill_s;
    logic [8:0]        energy_a_s, energy_b_s, energy_c_s, energy_sum_s;
    logic [7:0]        energy_n_s;
    logic signed [8:0] ax_s, ay_s, vx_n_s, vy_n_s, px_s, py_s;
    logic signed [7:0] x_n_s, y_n_s, bullet_x_n_s, bullet_y_n_s;
    logic [1:0]        bullet_dir_n_s;
    logic [2:0]        life_n_s;
    logic              bullet_active_n_s, shield_up_n_s, cloaked_n_s;

    // Next-state computation for one ship, assuming a step is taken.
    always_comb begin
      // Grants in priority order, each charged against what the earlier
      // grants left over; fire additionally needs the bullet slot free.
      fire_grant_s   = bus.attempt_fire[i] && !bullet_active_r &&
                       ({1'b0, energy_r} >= E_FIRE);
      energy_a_s     = {1'b0, energy_r} - (fire_grant_s ? E_FIRE : 9'd0);
      cloak_grant_s  = bus.attempt_cloak[i] && (energy_a_s >= E_CLOAK);
      energy_b_s     = energy_a_s - (cloak_grant_s ? E_CLOAK : 9'd0);
      shield_grant_s = bus.attempt_shield[i] && (energy_b_s >= E_SHIELD);
      energy_c_s     = energy_b_s - (shield_grant_s ? E_SHIELD : 9'd0);
      energy_sum_s   = energy_c_s + E_RECOUP;
      if (energy_sum_s > E_MAX) begin
        energy_n_s = E_MAX8;
      end else begin
        energy_n_s = energy_sum_s[7:0];
      end

      ax_s   = clamp9($signed({{5{bus.x_a[i][3]}}, bus.x_a[i]}), ACC_LIM);
      ay_s   = clamp9($signed({{5{bus.y_a[i][3]}}, bus.y_a[i]}), ACC_LIM);
      vx_n_s = clamp9(vx_r + ax_s, SPD_LIM);
      vy_n_s = clamp9(vy_r + ay_s, SPD_LIM);
      px_s   = $signed({x_r[7], x_r}) + vx_n_s;
      py_s   = $signed({y_r[7], y_r}) + vy_n_s;
      x_n_s  = store_pos(px_s);
      y_n_s  = store_pos(py_s);

      // Shield protects only if it was already up before this step.
      kill_s = off_board(px_s) || off_board(py_s) ||
               (bus.hit[i] && !shield_up_r);

      shield_up_n_s     = shield_grant_s;
      cloaked_n_s       = cloak_grant_s;
      bullet_active_n_s = bullet_active_r;
      bullet_x_n_s      = bullet_x_r;
      bullet_y_n_s      = bullet_y_r;
      bullet_dir_n_s    = bullet_dir_r;
      life_n_s          = life_r;

      // A grant only happens with the slot empty, so it never races expiry.
      if (fire_grant_s) begin
        bullet_active_n_s = 1'b1;
        bullet_x_n_s      = x_n_s;
        bullet_y_n_s      = y_n_s;
        bullet_dir_n_s    = bus.fire_dir[i];
        life_n_s          = LIFE_INIT;
      end else if (bullet_active_r) begin
        life_n_s = life_r - 3'd1;
        if (life_r == 3'd1) begin
          bullet_active_n_s = 1'b0;
        end else begin
          case (bullet_dir_r)
            DIR_RIGHT: bullet_x_n_s = bullet_x_r + B_STEP;
            DIR_DOWN:  bullet_y_n_s = bullet_y_r - B_STEP;
            DIR_LEFT:  bullet_x_n_s = bullet_x_r - B_STEP;
            DIR_UP:    bullet_y_n_s = bullet_y_r + B_STEP;
            default:   bullet_x_n_s = bullet_x_r;
          endcase
        end
      end else begin
        bullet_active_n_s = 1'b0;
      end

      // A ship destroyed this step leaves no shield, cloak, bullet or motion.
      if (kill_s) begin
        vx_n_s            = 9'sd0;
        vy_n_s            = 9'sd0;
        shield_up_n_s     = 1'b0;
        cloaked_n_s       = 1'b0;
        bullet_active_n_s = 1'b0;
      end else begin
        bullet_dir_n_s = bullet_dir_n_s;
      end
    end

    // Ship state registers; destroyed ships and idle cycles hold everything.
    always_ff @(posedge clk) begin
      if (reset) begin
        x_r             <= X_RESET;
        y_r             <= Y_RESET;
        vx_r            <= 9'sd0;
        vy_r            <= 9'sd0;
        energy_r        <= E_MAX8;
        destroyed_r     <= 1'b0;
        shield_up_r     <= 1'b0;
        cloaked_r       <= 1'b0;
        bullet_active_r <= 1'b0;
        bullet_x_r      <= 8'sd0;
        bullet_y_r      <= 8'sd0;
        bullet_dir_r    <= 2'd0;
        life_r          <= 3'd0;
      end else if (bus.step && !destroyed_r) begin
        x_r             <= x_n_s;
        y_r             <= y_n_s;
        vx_r            <= vx_n_s;
        vy_r            <= vy_n_s;
        energy_r        <= energy_n_s;
        destroyed_r     <= kill_s;
        shield_up_r     <= shield_up_n_s;
        cloaked_r       <= cloaked_n_s;
        bullet_active_r <= bullet_active_n_s;
        bullet_x_r      <= bullet_x_n_s;
        bullet_y_r      <= bullet_y_n_s;
        bullet_dir_r    <= bullet_dir_n_s;
        life_r          <= life_n_s;
      end
    end

    assign bus.x[i]             = x_r;
    assign bus.y[i]             = y_r;
    assign bus.energy[i]        = energy_r;
    assign bus.destroyed[i]     = destroyed_r;
    assign bus.shield_up[i]     = shield_up_r;
    assign bus.cloaked[i]       = cloaked_r;
    assign bus.bullet_active[i] = bullet_active_r;
    assign bus.bullet_x[i]      = bullet_x_r;
    assign bus.bullet_y[i]      = bullet_y_r;
    assign bus.bullet_dir[i]    = bullet_dir_r;
  end

endmodule

// File: tb/tb_ship_action_engine.sv
// tb_ship_action_engine
//   Directed scenarios for ship_action_engine with hand-computed expectations.
module tb_ship_action_engine;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ship_action_engine_if #(.NUM_SHIPS(3)) bus();

  ship_action_engine #(.NUM_SHIPS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.x_a[i]            = 4'sd0;
      bus.y_a[i]            = 4'sd0;
      bus.attempt_fire[i]   = 1'b0;
      bus.attempt_shield[i] = 1'b0;
      bus.attempt_cloak[i]  = 1'b0;
      bus.fire_dir[i]       = 2'd0;
      bus.hit[i]            = 1'b0;
    end
  endtask

  task automatic do_step();
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus.x[i] !== 8'(-40) || bus.y[i] !== 8'((i - 1) * 16)) begin
        fails++;
        $display("FAIL reset_pos ship%0d: got (%0d,%0d) expected (-40,%0d)",
                 i, bus.x[i], bus.y[i], (i - 1) * 16);
      end
      tests++;
      if (bus.energy[i] !== 8'd80 || bus.destroyed[i] !== 1'b0 ||
          bus.bullet_active[i] !== 1'b0 || bus.shield_up[i] !== 1'b0 ||
          bus.cloaked[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state ship%0d: energy %0d destroyed %0b bullet %0b shield %0b cloak %0b, expected 80 0 0 0 0",
                 i, bus.energy[i], bus.destroyed[i], bus.bullet_active[i],
                 bus.shield_up[i], bus.cloaked[i]);
      end
    end
  endtask

  task automatic test_hold();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.x_a[i] = 4'sd3;
      bus.attempt_fire[i] = 1'b1;
      bus.hit[i] = 1'b1;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (bus.x[0] !== 8'(-40) || bus.bullet_active[0] !== 1'b0 ||
        bus.energy[0] !== 8'd80 || bus.destroyed[0] !== 1'b0) begin
      fails++;
      $display("FAIL hold_no_step: x %0d bullet %0b energy %0d destroyed %0b, expected -40 0 80 0",
               bus.x[0], bus.bullet_active[0], bus.energy[0], bus.destroyed[0]);
    end
  endtask

  task automatic test_accel();
    int exp_x [3] = '{-37, -31, -22};
    clear_inputs();
    do_reset();
    bus.x_a[0] = 4'sd3;
    for (int k = 0; k < 3; k++) begin
      do_step();
      tests++;
      if (bus.x[0] !== 8'(exp_x[k]) || bus.energy[0] !== 8'd80) begin
        fails++;
        $display("FAIL accel step%0d: x %0d energy %0d, expected %0d 80",
                 k + 1, bus.x[0], bus.energy[0], exp_x[k]);
      end
    end
  endtask

  task automatic test_grants();
    clear_inputs();
    do_reset();
    bus.attempt_fire[0]   = 1'b1;
    bus.attempt_cloak[0]  = 1'b1;
    bus.attempt_shield[0] = 1'b1;
    do_step();
    tests++;
    if (bus.bullet_active[0] !== 1'b1 || bus.cloaked[0] !== 1'b1 ||
        bus.shield_up[0] !== 1'b1 || bus.energy[0] !== 8'd25) begin
      fails++;
      $display("FAIL grants_all: bullet %0b cloak %0b shield %0b energy %0d, expected 1 1 1 25",
               bus.bullet_active[0], bus.cloaked[0], bus.shield_up[0], bus.energy[0]);
    end
    do_step();
    tests++;
    if (bus.bullet_active[0] !== 1'b1 || bus.bullet_x[0] !== 8'(-31) ||
        bus.cloaked[0] !== 1'b1 || bus.shield_up[0] !== 1'b0 ||
        bus.energy[0] !== 8'd25) begin
      fails++;
      $display("FAIL grants_second: bullet %0b bx %0d cloak %0b shield %0b energy %0d, expected 1 -31 1 0 25",
               bus.bullet_active[0], bus.bullet_x[0], bus.cloaked[0],
               bus.shield_up[0], bus.energy[0]);
    end
  endtask

  task automatic test_bullet();
    clear_inputs();
    do_reset();
    bus.attempt_fire[1] = 1'b1;
    bus.fire_dir[1]     = 2'd3;
    for (int k = 1; k <= 6; k++) begin
      do_step();
      tests++;
      if (bus.bullet_active[1] !== 1'b1 || bus.bullet_y[1] !== 8'(9 * (k - 1)) ||
          bus.bullet_x[1] !== 8'(-40) || bus.bullet_dir[1] !== 2'd3) begin
        fails++;
        $display("FAIL bullet_flight step%0d: active %0b at (%0d,%0d) dir %0d, expected 1 at (-40,%0d) dir 3",
                 k, bus.bullet_active[1], bus.bullet_x[1], bus.bullet_y[1],
                 bus.bullet_dir[1], 9 * (k - 1));
      end
    end
    do_step();
    tests++;
    if (bus.bullet_active[1] !== 1'b0) begin
      fails++;
      $display("FAIL bullet_expire: active %0b expected 0", bus.bullet_active[1]);
    end
    do_step();
    tests++;
    if (bus.bullet_active[1] !== 1'b1 || bus.bullet_y[1] !== 8'sd0 ||
        bus.energy[1] !== 8'd65) begin
      fails++;
      $display("FAIL bullet_refire: active %0b by %0d energy %0d, expected 1 0 65",
               bus.bullet_active[1], bus.bullet_y[1], bus.energy[1]);
    end
  endtask

  task automatic test_shield_hit();
    clear_inputs();
    do_reset();
    bus.attempt_shield[2] = 1'b1;
    do_step();
    tests++;
    if (bus.shield_up[2] !== 1'b1 || bus.energy[2] !== 8'd70) begin
      fails++;
      $display("FAIL shield_raise: shield %0b energy %0d, expected 1 70",
               bus.shield_up[2], bus.energy[2]);
    end
    bus.attempt_shield[2] = 1'b0;
    bus.hit[2] = 1'b1;
    do_step();
    tests++;
    if (bus.destroyed[2] !== 1'b0 || bus.shield_up[2] !== 1'b0 ||
        bus.energy[2] !== 8'd80) begin
      fails++;
      $display("FAIL hit_shielded: destroyed %0b shield %0b energy %0d, expected 0 0 80",
               bus.destroyed[2], bus.shield_up[2], bus.energy[2]);
    end
    bus.attempt_shield[2] = 1'b1;
    do_step();
    tests++;
    if (bus.destroyed[2] !== 1'b1 || bus.energy[2] !== 8'd70) begin
      fails++;
      $display("FAIL hit_same_step_shield: destroyed %0b energy %0d, expected 1 70",
               bus.destroyed[2], bus.energy[2]);
    end
    bus.x_a[2] = 4'sd4;
    bus.y_a[2] = -4'sd4;
    bus.attempt_fire[2]  = 1'b1;
    bus.attempt_cloak[2] = 1'b1;
    do_step();
    do_step();
    tests++;
    if (bus.x[2] !== 8'(-40) || bus.y[2] !== 8'sd16 || bus.energy[2] !== 8'd70 ||
        bus.destroyed[2] !== 1'b1 || bus.shield_up[2] !== 1'b0 ||
        bus.cloaked[2] !== 1'b0 || bus.bullet_active[2] !== 1'b0) begin
      fails++;
      $display("FAIL destroyed_frozen: (%0d,%0d) energy %0d destroyed %0b shield %0b cloak %0b bullet %0b, expected (-40,16) 70 1 0 0 0",
               bus.x[2], bus.y[2], bus.energy[2], bus.destroyed[2],
               bus.shield_up[2], bus.cloaked[2], bus.bullet_active[2]);
    end
  endtask

  task automatic test_speed_clamp();
    int exp_x [9] = '{-36, -28, -16, 0, 16, 32, 48, 64, 127};
    int exp_y [6] = '{-4, -12, -24, -40, -56, -127};
    clear_inputs();
    do_reset();
    bus.x_a[0] = 4'sd7;
    bus.y_a[1] = -4'sd8;
    for (int k = 0; k < 10; k++) begin
      do_step();
      tests++;
      if (bus.x[0] !== 8'(exp_x[(k < 9) ? k : 8]) ||
          bus.destroyed[0] !== ((k >= 8) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL speed_clamp_x step%0d: x %0d destroyed %0b, expected %0d %0b",
                 k + 1, bus.x[0], bus.destroyed[0], exp_x[(k < 9) ? k : 8], k >= 8);
      end
      if (k < 6) begin
        tests++;
        if (bus.y[1] !== 8'(exp_y[k]) || bus.destroyed[1] !== ((k == 5) ? 1'b1 : 1'b0)) begin
          fails++;
          $display("FAIL speed_clamp_y step%0d: y %0d destroyed %0b, expected %0d %0b",
                   k + 1, bus.y[1], bus.destroyed[1], exp_y[k], k == 5);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    do_reset();
    bus.attempt_fire[0]  = 1'b1;
    bus.attempt_cloak[0] = 1'b1;
    bus.fire_dir[0]      = 2'd2;
    do_step();
    bus.attempt_fire[0] = 1'b0;
    bus.x_a[0] = 4'sd2;
    do_step();
    tests++;
    if (bus.bullet_active[0] !== 1'b1 || bus.bullet_x[0] !== 8'(-49)) begin
      fails++;
      $display("FAIL midflight_pre: active %0b bx %0d, expected 1 -49",
               bus.bullet_active[0], bus.bullet_x[0]);
    end
    @(negedge clk);
    bus.step = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    reset    = 1'b0;
    tests++;
    if (bus.bullet_active[0] !== 1'b0 || bus.bullet_x[0] !== 8'sd0 ||
        bus.bullet_y[0] !== 8'sd0 || bus.bullet_dir[0] !== 2'd0 ||
        bus.x[0] !== 8'(-40) || bus.energy[0] !== 8'd80 || bus.cloaked[0] !== 1'b0) begin
      fails++;
      $display("FAIL midflight_reset: active %0b b(%0d,%0d) dir %0d x %0d energy %0d cloak %0b, expected 0 (0,0) 0 -40 80 0",
               bus.bullet_active[0], bus.bullet_x[0], bus.bullet_y[0],
               bus.bullet_dir[0], bus.x[0], bus.energy[0], bus.cloaked[0]);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_hold();
    test_accel();
    test_grants();
    test_bullet();
    test_shield_hit();
    test_speed_clamp();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
